ex_mem_buffer: RTL and testbench
================================

EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ex_valid, input, 1 bit: the execute-stage entry is valid.
REQ-004 SHALL have port ex_ready, output, 1 bit: the buffer can accept an entry this cycle.
REQ-005 SHALL have port alu_result, input, 32 bits: ALU output C (the memory address or the writeback value).
REQ-006 SHALL have port store_data, input, 32 bits: rs2 value for stores.
REQ-007 SHALL have ports rd (input, 5 bits), reg_wr, mem_rd and mem_wr (input, 1 bit each), and funct3 (input, 3 bits): destination register and control.
REQ-008 SHALL have port flush, input, 1 bit: discards all held and incoming entries.
REQ-009 SHALL have port mem_valid, output, 1 bit: the head entry is presented to the memory stage.
REQ-010 SHALL have port mem_ready, input, 1 bit: the memory/cache stage consumes the head entry.
REQ-011 SHALL have output ports m_alu_result (32 bits), m_store_data (32 bits), m_rd (5 bits), m_reg_wr, m_mem_rd, m_mem_wr (1 bit each), m_funct3 (3 bits) and m_misalign (1 bit): the head entry fields.

Function
REQ-012 SHALL be a 2-entry skid buffer with states EMPTY, ONE and FULL; a head entry and a skid entry.
REQ-013 SHALL define accept = ex_valid & ex_ready, and pop = mem_valid & mem_ready.
REQ-014 SHALL drive ex_ready = (state != FULL), decoded from the state register only, with no combinational path from mem_ready.
REQ-015 SHALL drive mem_valid = (state != EMPTY); all m_* outputs come from registers of the head entry.
REQ-016 SHALL make the following transitions:
- EMPTY: accept -> ONE (head = in).
- ONE: accept & pop -> ONE (head = in); accept only -> FULL (skid = in); pop only -> EMPTY.
- FULL: pop -> ONE (head = skid); otherwise hold.
REQ-017 SHALL hold every field of the head entry while mem_valid=1 and mem_ready=0.
REQ-018 SHALL, on flush=1, go to EMPTY at the next edge, regardless of accept or pop in that cycle; the incoming entry is dropped.
REQ-019 SHALL compute misalign on accept when mem_rd|mem_wr, using funct3[1:0]:
- 00 (byte): never misaligned.
- 01 (half): alu_result[0]!=0.
- 10 (word): alu_result[1:0]!=0.
- 11: always misaligned.
REQ-020 SHALL store misalign with the entry.
REQ-021 SHALL store misalign=0 when mem_rd=mem_wr=0.
REQ-022 SHALL have a latency of 1 cycle from accept to mem_valid when the buffer is EMPTY; throughput SHALL be 1 entry/cycle while mem_ready=1.
REQ-023 SHALL store entries in order; entries SHALL never be reordered or duplicated.

Reset
REQ-024 SHALL, while reset=0, force state to EMPTY and both entries to all-zero fields, independent of clk.
REQ-025 SHALL drive the following during reset: ex_ready=1, mem_valid=0, all m_* outputs=0.
REQ-026 SHALL lose held entries on reset asserted mid-transfer; the first accept after release SHALL behave as in EMPTY.

Configuration
REQ-027 SHALL, when EX_MEM_FWD_EN is defined, add the following outputs:
- fwd_valid (1 bit) = mem_valid & m_reg_wr & ~m_mem_rd & (m_rd!=0).
- fwd_rd (5 bits) = m_rd.
- fwd_data (32 bits) = m_alu_result.
REQ-028 SHALL, when EX_MEM_FWD_EN is not defined, have no fwd_* ports and no logic for them; all other behaviour SHALL be identical.

Structure
REQ-029 SHALL place in the shared package: the buffer-state enum (EMPTY/ONE/FULL), the entry struct (alu_result, store_data, rd, reg_wr, mem_rd, mem_wr, funct3, misalign) and the funct3 size constants (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2).
REQ-030 SHALL contain one sub-module, mem_align_check: combinational, with inputs addr[1:0], funct3 and mem_access, and output misalign.

Verification
REQ-031 SHALL cover the following directed scenarios:
- Accept with the buffer EMPTY: ex_valid=1, alu_result=0x0000_1004, funct3=010, mem_rd=1, mem_ready=1 -> next cycle mem_valid=1, m_alu_result=0x1004, m_misalign=0.
- Misalignment: a word store to 0x1006 -> m_misalign=1; a half load from 0x1006 -> m_misalign=0; a half load from 0x1007 -> m_misalign=1.
- Backpressure: mem_ready=0 while entries A, B, C are offered -> A is head, B is skid, ex_ready=0 and C is held upstream. Then mem_ready=1 -> A, B, C are popped in order on consecutive cycles.
- Flush: in FULL, flush=1 with ex_valid=1 -> next cycle mem_valid=0, ex_ready=1, and the incoming entry never appears.
- Reset: reset=0 asserted asynchronously between edges while in ONE -> mem_valid=0 and m_* outputs=0 immediately; after release, a new entry appears after 1 cycle.
- EX_MEM_FWD_EN defined: an ALU op with rd=5, reg_wr=1, result 0xDEAD_BEEF -> fwd_valid=1, fwd_rd=5, fwd_data=0xDEADBEEF. The same op with rd=0, or a load, -> fwd_valid=0.

Source files
------------

// File: rtl/ex_mem_buffer_pkg.sv
// rtl/ex_mem_buffer_pkg.sv - shared types and constants for the EX/MEM skid buffer
package ex_mem_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  funct3;
        logic        misalign;
    } entry_t;

    // Access size encoded in funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam entry_t ENTRY_ZERO = '0;

endpackage

// File: rtl/ex_mem_buffer_align.sv
// rtl/ex_mem_buffer_align.sv - combinational address alignment check for loads/stores
module mem_align_check
    import ex_mem_buffer_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] funct3,
    input  logic       mem_access,
    output logic       misalign
);

    // funct3[2] only selects sign extension, which does not affect alignment
    logic unused_funct3_msb;
    assign unused_funct3_msb = funct3[2];

    always_comb begin
        misalign = 1'b0;
        if (mem_access) begin
            case (funct3[1:0])
                SZ_BYTE: misalign = 1'b0;
                SZ_HALF: misalign = addr[0];
                SZ_WORD: misalign = |addr;
                default: misalign = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_buffer.sv
// rtl/ex_mem_buffer.sv - 2-entry EX/MEM skid buffer; EX_MEM_FWD_EN adds forwarding outputs
module ex_mem_buffer
    import ex_mem_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    input  logic        reg_wr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic        flush,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] m_alu_result,
    output logic [31:0] m_store_data,
    output logic [4:0]  m_rd,
    output logic        m_reg_wr,
    output logic        m_mem_rd,
    output logic        m_mem_wr,
    output logic [2:0]  m_funct3,
    output logic        m_misalign
`ifdef EX_MEM_FWD_EN
    ,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data
`endif
);

    buf_state_e state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    entry_t     in_entry;
    logic       in_misalign;
    logic       accept;
    logic       pop;

    mem_align_check u_align (
        .addr       (alu_result[1:0]),
        .funct3     (funct3),
        .mem_access (mem_rd | mem_wr),
        .misalign   (in_misalign)
    );

    always_comb begin
        in_entry            = ENTRY_ZERO;
        in_entry.alu_result = alu_result;
        in_entry.store_data = store_data;
        in_entry.rd         = rd;
        in_entry.reg_wr     = reg_wr;
        in_entry.mem_rd     = mem_rd;
        in_entry.mem_wr     = mem_wr;
        in_entry.funct3     = funct3;
        in_entry.misalign   = in_misalign;
    end

    // ex_ready depends only on state_q so upstream never sees mem_ready combinationally
    assign ex_ready  = (state_q != FULL);
    assign mem_valid = (state_q != EMPTY);
    assign accept    = ex_valid & ex_ready;
    assign pop       = mem_valid & mem_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    head_d  = in_entry;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_d = in_entry;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_entry;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any accept or pop; stale entry contents are masked by mem_valid
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            head_q  <= ENTRY_ZERO;
            skid_q  <= ENTRY_ZERO;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign m_alu_result = head_q.alu_result;
    assign m_store_data = head_q.store_data;
    assign m_rd         = head_q.rd;
    assign m_reg_wr     = head_q.reg_wr;
    assign m_mem_rd     = head_q.mem_rd;
    assign m_mem_wr     = head_q.mem_wr;
    assign m_funct3     = head_q.funct3;
    assign m_misalign   = head_q.misalign;

`ifdef EX_MEM_FWD_EN
    assign fwd_valid = mem_valid & head_q.reg_wr & ~head_q.mem_rd & (head_q.rd != 5'd0);
    assign fwd_rd    = head_q.rd;
    assign fwd_data  = head_q.alu_result;
`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb/tb_ex_mem_buffer.sv - directed self-checking bench for ex_mem_buffer (EX_MEM_FWD_EN optional)
module tb_ex_mem_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] m_alu_result;
    logic [31:0] m_store_data;
    logic [4:0]  m_rd;
    logic        m_reg_wr;
    logic        m_mem_rd;
    logic        m_mem_wr;
    logic [2:0]  m_funct3;
    logic        m_misalign;
`ifdef EX_MEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_mem_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .rd           (rd),
        .reg_wr       (reg_wr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .funct3       (funct3),
        .flush        (flush),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .m_alu_result (m_alu_result),
        .m_store_data (m_store_data),
        .m_rd         (m_rd),
        .m_reg_wr     (m_reg_wr),
        .m_mem_rd     (m_mem_rd),
        .m_mem_wr     (m_mem_wr),
        .m_funct3     (m_funct3),
        .m_misalign   (m_misalign)
`ifdef EX_MEM_FWD_EN
        ,
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] a, input logic [4:0] r, input logic rw,
                         input logic lr, input logic sw, input logic [2:0] f3);
        ex_valid   = 1'b1;
        alu_result = a;
        store_data = ~a;
        rd         = r;
        reg_wr     = rw;
        mem_rd     = lr;
        mem_wr     = sw;
        funct3     = f3;
    endtask

    initial begin
        reset = 1'b0; ex_valid = 1'b0; alu_result = '0; store_data = '0; rd = '0;
        reg_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = '0; flush = 1'b0;
        mem_ready = 1'b0;
        #2;
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_m_alu", m_alu_result, 32'd0);
        check("rst_m_misalign", 32'(m_misalign), 32'd0);
        step();
        reset = 1'b1;

        // Accept from EMPTY, 1-cycle latency
        mem_ready = 1'b1;
        offer(32'h0000_1004, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010);
        step();
        check("acc_mem_valid", 32'(mem_valid), 32'd1);
        check("acc_m_alu", m_alu_result, 32'h0000_1004);
        check("acc_m_misalign", 32'(m_misalign), 32'd0);
        check("acc_m_store", m_store_data, 32'hFFFF_EFFB);
        check("acc_m_rd", 32'(m_rd), 32'd3);
        ex_valid = 1'b0;
        step();
        check("acc_drain", 32'(mem_valid), 32'd0);

        // Misalignment, one entry per cycle through the head
        offer(32'h0000_1006, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010);
        step();
        check("mis_word_1006", 32'(m_misalign), 32'd1);
        offer(32'h0000_1006, 5'd4, 1'b1, 1'b1, 1'b0, 3'b001);
        step();
        check("mis_half_1006", 32'(m_misalign), 32'd0);
        check("mis_half_1006_a", m_alu_result, 32'h0000_1006);
        offer(32'h0000_1007, 5'd4, 1'b1, 1'b1, 1'b0, 3'b001);
        step();
        check("mis_half_1007", 32'(m_misalign), 32'd1);
        offer(32'h0000_1007, 5'd6, 1'b1, 1'b0, 1'b0, 3'b011);
        step();
        check("mis_alu_op", 32'(m_misalign), 32'd0);
        offer(32'h0000_2003, 5'd0, 1'b0, 1'b1, 1'b0, 3'b100);
        step();
        check("mis_byte", 32'(m_misalign), 32'd0);
        offer(32'h0000_2000, 5'd0, 1'b0, 1'b1, 1'b0, 3'b011);
        step();
        check("mis_f3_11", 32'(m_misalign), 32'd1);
        ex_valid = 1'b0;
        step();
        check("mis_drain", 32'(mem_valid), 32'd0);

        // Backpressure: A head, B skid, C held upstream
        mem_ready = 1'b0;
        offer(32'h0000_00A0, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        check("bp_a_head", m_alu_result, 32'h0000_00A0);
        check("bp_one_ready", 32'(ex_ready), 32'd1);
        offer(32'h0000_00B0, 5'd2, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        check("bp_full_ready", 32'(ex_ready), 32'd0);
        check("bp_a_still", m_alu_result, 32'h0000_00A0);
        offer(32'h0000_00C0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        check("bp_hold_a", m_alu_result, 32'h0000_00A0);
        check("bp_hold_rd", 32'(m_rd), 32'd1);
        check("bp_hold_valid", 32'(mem_valid), 32'd1);
        check("bp_hold_ready", 32'(ex_ready), 32'd0);
        mem_ready = 1'b1;
        step();
        check("bp_pop_b", m_alu_result, 32'h0000_00B0);
        check("bp_b_ready", 32'(ex_ready), 32'd1);
        step();
        check("bp_pop_c", m_alu_result, 32'h0000_00C0);
        check("bp_c_valid", 32'(mem_valid), 32'd1);
        ex_valid = 1'b0;
        step();
        check("bp_drain", 32'(mem_valid), 32'd0);

        // Flush in FULL with an incoming entry
        mem_ready = 1'b0;
        offer(32'h0000_00D0, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        offer(32'h0000_00E0, 5'd2, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        check("fl_full", 32'(ex_ready), 32'd0);
        flush = 1'b1;
        offer(32'h0000_00F0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        check("fl_mem_valid", 32'(mem_valid), 32'd0);
        check("fl_ex_ready", 32'(ex_ready), 32'd1);
        flush = 1'b0;
        ex_valid = 1'b0;
        mem_ready = 1'b1;
        step();
        check("fl_no_ghost", 32'(mem_valid), 32'd0);

        // Asynchronous reset while in ONE
        mem_ready = 1'b0;
        offer(32'h0000_0123, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        ex_valid = 1'b0;
        check("ar_in_one", 32'(mem_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_mem_valid", 32'(mem_valid), 32'd0);
        check("ar_m_alu", m_alu_result, 32'd0);
        check("ar_m_rd", 32'(m_rd), 32'd0);
        check("ar_m_reg_wr", 32'(m_reg_wr), 32'd0);
        check("ar_ex_ready", 32'(ex_ready), 32'd1);
        step();
        reset = 1'b1;
        offer(32'h0000_0456, 5'd8, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        check("ar_post_valid", 32'(mem_valid), 32'd1);
        check("ar_post_alu", m_alu_result, 32'h0000_0456);
        ex_valid = 1'b0;
        mem_ready = 1'b1;
        step();

`ifdef EX_MEM_FWD_EN
        offer(32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        check("fwd_valid", 32'(fwd_valid), 32'd1);
        check("fwd_rd", 32'(fwd_rd), 32'd5);
        check("fwd_data", fwd_data, 32'hDEAD_BEEF);
        offer(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        check("fwd_rd0", 32'(fwd_valid), 32'd0);
        offer(32'hDEAD_BEEF, 5'd5, 1'b1, 1'b1, 1'b0, 3'b010);
        step();
        check("fwd_load", 32'(fwd_valid), 32'd0);
        ex_valid = 1'b0;
        step();
        check("fwd_empty", 32'(fwd_valid), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
